// File: rtl/mux_arb_pkg.sv
// Package: mux_arb_pkg
// Shared constants for the round-robin mux arbiter: the FSM state encoding
// and default parameter values for N, SEL_W and MAX_HOLD.
// Optional feature macro used by mux_rr_arbiter: MUX_ARB_PARK_EN.
package mux_arb_pkg;

    // FSM state encoding
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    // Default build parameters
    localparam int DEF_N        = 8;
    localparam int DEF_SEL_W    = 3;
    localparam int DEF_MAX_HOLD = 16;

endpackage

// File: rtl/mux_rr_pick.sv
// Module: mux_rr_pick
// Combinational round-robin picker. It finds the first set request bit,
// scanning upward from i_ptr+1 and wrapping modulo N.
// The search is done in three steps:
//   1. rotate the request vector so that index i_ptr+1 lands at bit 0;
//   2. priority-encode the lowest set bit;
//   3. un-rotate that position back to a real requester index.
// Ports:
//   i_req     in   N      request vector
//   i_ptr     in   SEL_W  index of the last winner (lowest priority)
//   o_winner  out  SEL_W  index of the chosen requester
//   o_found   out  1      at least one request bit is set
import mux_arb_pkg::*;

module mux_rr_pick #(
    parameter int N     = DEF_N,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic [N-1:0]     i_req,
    input  logic [SEL_W-1:0] i_ptr,
    output logic [SEL_W-1:0] o_winner,
    output logic             o_found
);

    // One extra bit holds sums up to 2N-1 before wrapping.
    localparam int             IW  = SEL_W + 1;
    localparam logic [IW-1:0]  N_W = IW'(N);

    // Modulo-N reduction for a sum that is known to be below 2N.
    function automatic logic [SEL_W-1:0] wrap_n(input logic [IW-1:0] v);
        return (v >= N_W) ? SEL_W'(v - N_W) : SEL_W'(v);
    endfunction

    logic [N-1:0]     w_rot;
    logic [SEL_W-1:0] w_pos;

    // w_rot[k] holds the request of requester (i_ptr + 1 + k) mod N.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IW-1:0] w_idx;
            assign w_idx     = IW'(gi) + {1'b0, i_ptr} + IW'(1);
            assign w_rot[gi] = i_req[wrap_n(w_idx)];
        end
    endgenerate

    // Lowest set bit of the rotated vector. The loop runs downward so the
    // last assignment made is the lowest index.
    always_comb begin
        w_pos = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_pos = SEL_W'(i);
            end
        end
    end

    assign o_winner = wrap_n({1'b0, w_pos} + {1'b0, i_ptr} + IW'(1));
    assign o_found  = |i_req;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Module: mux_rr_arbiter
// Round-robin arbiter that owns the select of an N-input mux. Grants are
// registered and held until one of two things happens:
//   - the owner drops its request, or
//   - MAX_HOLD cycles have elapsed.
// Each grant is followed by at least one idle cycle (break-before-make).
// Optional feature: define MUX_ARB_PARK_EN to keep sel parked on the last
// winner while idle. Without it, sel returns to 0 when the grant is released.
// Ports:
//   clk      in   1      rising-edge clock
//   rst_n    in   1      asynchronous active-low reset
//   en       in   1      permits new grants (ignored while a grant is held)
//   req      in   N      level requests
//   gnt      out  N      one-hot registered grant
//   gnt_vld  out  1      grant active
//   sel      out  SEL_W  registered mux select
import mux_arb_pkg::*;

module mux_rr_arbiter #(
    parameter int N        = DEF_N,
    parameter int SEL_W    = DEF_SEL_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic             gnt_vld,
    output logic [SEL_W-1:0] sel
);

    localparam int              HC_W      = $clog2(MAX_HOLD + 1);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

    logic [0:0]       r_state;
    logic [N-1:0]     r_gnt;
    logic             r_gnt_vld;
    logic [SEL_W-1:0] r_sel;
    logic [SEL_W-1:0] r_ptr;
    logic [HC_W-1:0]  r_hold_cnt;

    logic [SEL_W-1:0] w_winner;
    logic             w_found;
    logic             w_release;

    mux_rr_pick #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req    (req),
        .i_ptr    (r_ptr),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // While in GRANT, r_sel always holds the current winner. A request drop
    // and hold expiry in the same cycle both lead to a single release.
    assign w_release = ~req[r_sel] | (r_hold_cnt == HOLD_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_vld  <= 1'b0;
            r_sel      <= '0;
            r_ptr      <= SEL_W'(N - 1);
            r_hold_cnt <= '0;
        end else if (r_state == ST_IDLE) begin
            if (en && w_found) begin
                r_state    <= ST_GRANT;
                r_gnt      <= N'(1) << w_winner;
                r_gnt_vld  <= 1'b1;
                r_sel      <= w_winner;
                r_hold_cnt <= '0;
            end
        end else begin
            if (w_release) begin
                r_state   <= ST_IDLE;
                r_gnt     <= '0;
                r_gnt_vld <= 1'b0;
                r_ptr     <= r_sel;
`ifdef MUX_ARB_PARK_EN
                // Parked: leave the select on the last winner.
                r_sel     <= r_sel;
`else
                r_sel     <= '0;
`endif
            end else begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
        end
    end

    assign gnt     = r_gnt;
    assign gnt_vld = r_gnt_vld;
    assign sel     = r_sel;

endmodule
